// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the boot-time instruction memory loader.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    SYNC  = 3'd0,
    LEN   = 3'd1,
    DATA  = 3'd2,
    CHECK = 3'd3,
    DONE  = 3'd4,
    ERROR = 3'd5
  } state_e;

  localparam logic [7:0] SYNC_BYTE     = 8'hA5;
  localparam int         DEPTH_DEFAULT = 32;

endpackage

// File: rtl/imem_loader_word_assembler.sv
// Packs bytes MSB-first into 32-bit words; o_word/o_word_vld are valid
// combinationally on the cycle the 4th byte is presented.
module word_assembler (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_clr,
  input  logic        i_vld,
  input  logic [7:0]  i_dat,
  output logic [31:0] o_word,
  output logic        o_word_vld
);

  logic [23:0] r_shift;
  logic [1:0]  r_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_shift <= 24'd0;
      r_cnt   <= 2'd0;
    end else if (i_clr) begin
      r_shift <= 24'd0;
      r_cnt   <= 2'd0;
    end else if (i_vld) begin
      r_shift <= {r_shift[15:0], i_dat};
      r_cnt   <= r_cnt + 2'd1;
    end
  end

  assign o_word     = {r_shift, i_dat};
  assign o_word_vld = i_vld && (r_cnt == 2'd3);

endmodule

// File: rtl/imem_loader.sv
// Framed byte-stream loader: SYNC, LEN, 4*N data bytes, CSUM; writes big-endian
// words to instruction memory and releases cpu_reset only after a good frame.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int DEPTH_WORDS = DEPTH_DEFAULT,
  parameter int ADDR_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  rx_valid,
  input  logic [7:0]            rx_data,
  output logic                  rx_ready,
  input  logic                  start,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_waddr,
  output logic [31:0]           imem_wdata,
  output logic                  cpu_reset,
  output logic                  done,
  output logic                  error
);

  localparam logic [31:0] LP_DEPTH = DEPTH_WORDS;

  state_e                r_state;
  logic [7:0]            r_len;
  logic [7:0]            r_widx;
  logic [7:0]            r_sum;
  logic                  r_we;
  logic [ADDR_WIDTH-1:0] r_waddr;
  logic [31:0]           r_wdata;

  logic                  w_xfer;
  logic                  w_to_len;
  logic                  w_len_bad;
  logic                  w_word_vld;
  logic [31:0]           w_word;

  assign rx_ready = (r_state == SYNC) || (r_state == LEN) ||
                    (r_state == DATA) || (r_state == CHECK);

  // start takes priority over a same-cycle handshake, so that byte is dropped.
  assign w_xfer    = rx_valid && rx_ready && !start;
  assign w_to_len  = w_xfer && (r_state == SYNC) && (rx_data == SYNC_BYTE);
  assign w_len_bad = (rx_data == 8'd0) || ({24'd0, rx_data} > LP_DEPTH);

  word_assembler u_word_assembler (
    .clk        (clk),
    .reset      (reset),
    .i_clr      (start || w_to_len),
    .i_vld      (w_xfer && (r_state == DATA)),
    .i_dat      (rx_data),
    .o_word     (w_word),
    .o_word_vld (w_word_vld)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= SYNC;
      r_len   <= 8'd0;
      r_widx  <= 8'd0;
      r_sum   <= 8'd0;
      r_we    <= 1'b0;
      r_waddr <= '0;
      r_wdata <= 32'd0;
    end else begin
      r_we <= 1'b0;
      if (start) begin
        r_state <= SYNC;
      end else if (w_xfer) begin
        case (r_state)
          SYNC: begin
            if (rx_data == SYNC_BYTE) r_state <= LEN;
          end
          LEN: begin
            if (w_len_bad) begin
              r_state <= ERROR;
            end else begin
              r_len   <= rx_data;
              r_widx  <= 8'd0;
              r_sum   <= 8'd0;
              r_state <= DATA;
            end
          end
          DATA: begin
            r_sum <= r_sum + rx_data;
            if (w_word_vld) begin
              r_we    <= 1'b1;
              r_waddr <= ADDR_WIDTH'({r_widx, 2'b00});
              r_wdata <= w_word;
              r_widx  <= r_widx + 8'd1;
              if (r_widx == r_len - 8'd1) r_state <= CHECK;
            end
          end
          CHECK: begin
            r_state <= (rx_data == r_sum) ? DONE : ERROR;
          end
          default: begin
            r_state <= r_state;
          end
        endcase
      end
    end
  end

  assign imem_we    = r_we;
  assign imem_waddr = r_waddr;
  assign imem_wdata = r_wdata;
  assign done       = (r_state == DONE);
  assign error      = (r_state == ERROR);
  assign cpu_reset  = (r_state != DONE);

endmodule
